// File: rtl/pipeline_control_decoder.sv
// Main/ALU control decoder for the 5-stage RISC-V core, with D/E, E/M and M/W
// control pipeline registers. Handles cache-miss freezes and hazard bubbles.
module pipeline_control_decoder (
  input  logic       clk,
  input  logic       reset,
  input  logic       ihit,
  input  logic       dhit,
  input  logic [6:0] opcode,
  input  logic [2:0] funct3,
  input  logic [6:0] funct7,
  input  logic       sendNop,
  output logic       MemWriteD,
  output logic       LoadD,
  output logic       BranchD,
  output logic       JumpD,
  output logic       ByteD,
  output logic       ALUSrcE,
  output logic [2:0] ALUControl,
  output logic       BranchM,
  output logic       JumpM,
  output logic       LoadM,
  output logic       MemWrite,
  output logic       RegWrite,
  output logic       ByteW,
  output logic       MemtoRegW
);

  localparam int unsigned OP_W     = 7;
  localparam int unsigned F3_W     = 3;
  localparam int unsigned F7_W     = 7;
  localparam int unsigned ALUOP_W  = 2;
  localparam int unsigned ALUCTL_W = 3;

  localparam logic [OP_W-1:0] OP_RTYPE  = OP_W'(7'b0110011);
  localparam logic [OP_W-1:0] OP_IALU   = OP_W'(7'b0010011);
  localparam logic [OP_W-1:0] OP_LOAD   = OP_W'(7'b0000011);
  localparam logic [OP_W-1:0] OP_STORE  = OP_W'(7'b0100011);
  localparam logic [OP_W-1:0] OP_BRANCH = OP_W'(7'b1100011);
  localparam logic [OP_W-1:0] OP_JAL    = OP_W'(7'b1101111);

  localparam logic [F3_W-1:0] F3_BYTE = F3_W'(3'b000);

  localparam logic [F7_W-1:0] F7_ADD = F7_W'(7'b0000000);
  localparam logic [F7_W-1:0] F7_SUB = F7_W'(7'b0100000);
  localparam logic [F7_W-1:0] F7_MUL = F7_W'(7'b0000001);

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = ALUOP_W'(2'b00);
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = ALUOP_W'(2'b01);
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = ALUOP_W'(2'b10);

  localparam logic [ALUCTL_W-1:0] ALU_ADD = ALUCTL_W'(3'b000);
  localparam logic [ALUCTL_W-1:0] ALU_SUB = ALUCTL_W'(3'b001);
  localparam logic [ALUCTL_W-1:0] ALU_MUL = ALUCTL_W'(3'b010);

  typedef struct packed {
    logic                regwrite;
    logic                memwrite;
    logic                load;
    logic                branch;
    logic                jump;
    logic                bytesel;
    logic                alusrc;
    logic                memtoreg;
    logic [ALUCTL_W-1:0] alucontrol;
  } de_t;

  typedef struct packed {
    logic regwrite;
    logic memwrite;
    logic load;
    logic branch;
    logic jump;
    logic bytesel;
    logic memtoreg;
  } em_t;

  typedef struct packed {
    logic regwrite;
    logic bytesel;
    logic memtoreg;
  } mw_t;

  de_t                 dec;
  de_t                 de_d;
  logic [ALUOP_W-1:0]  aluop;
  logic [ALUCTL_W-1:0] alu_ctl;
  de_t                 de_q;
  em_t                 em_q;
  mw_t                 mw_q;

  // Main decode of the D-stage opcode
  always_comb begin
    dec   = '0;
    aluop = ALUOP_ADD;
    unique case (opcode)
      OP_RTYPE: begin
        dec.regwrite = 1'b1;
        aluop        = ALUOP_FUNCT;
      end
      OP_IALU: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
      end
      OP_LOAD: begin
        dec.regwrite = 1'b1;
        dec.alusrc   = 1'b1;
        dec.load     = 1'b1;
        dec.memtoreg = 1'b1;
        dec.bytesel  = (funct3 == F3_BYTE);
      end
      OP_STORE: begin
        dec.alusrc   = 1'b1;
        dec.memwrite = 1'b1;
        dec.bytesel  = (funct3 == F3_BYTE);
      end
      OP_BRANCH: begin
        dec.branch = 1'b1;
        aluop      = ALUOP_SUB;
      end
      OP_JAL: begin
        dec.jump     = 1'b1;
        dec.regwrite = 1'b1;
      end
      default: begin
        dec   = '0;
        aluop = ALUOP_ADD;
      end
    endcase
  end

  // ALU operation select from aluop and funct7
  always_comb begin
    alu_ctl = ALU_ADD;
    if (aluop == ALUOP_SUB) begin
      alu_ctl = ALU_SUB;
    end else if (aluop == ALUOP_FUNCT) begin
      unique case (funct7)
        F7_ADD:  alu_ctl = ALU_ADD;
        F7_SUB:  alu_ctl = ALU_SUB;
        F7_MUL:  alu_ctl = ALU_MUL;
        default: alu_ctl = ALU_ADD;
      endcase
    end
  end

  // A hazard request turns the D instruction into a bubble immediately
  always_comb begin
    de_d            = dec;
    de_d.alucontrol = alu_ctl;
    if (sendNop) begin
      de_d = '0;
    end
  end

  assign MemWriteD = de_d.memwrite;
  assign LoadD     = de_d.load;
  assign BranchD   = de_d.branch;
  assign JumpD     = de_d.jump;
  assign ByteD     = de_d.bytesel;

  // Data miss freezes everything; a fetch miss only bubbles D/E
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else if (dhit) begin
      de_q          <= ihit ? de_d : '0;
      em_q.regwrite <= de_q.regwrite;
      em_q.memwrite <= de_q.memwrite;
      em_q.load     <= de_q.load;
      em_q.branch   <= de_q.branch;
      em_q.jump     <= de_q.jump;
      em_q.bytesel  <= de_q.bytesel;
      em_q.memtoreg <= de_q.memtoreg;
      mw_q.regwrite <= em_q.regwrite;
      mw_q.bytesel  <= em_q.bytesel;
      mw_q.memtoreg <= em_q.memtoreg;
    end
  end

  assign ALUSrcE    = de_q.alusrc;
  assign ALUControl = de_q.alucontrol;
  assign BranchM    = em_q.branch;
  assign JumpM      = em_q.jump;
  assign LoadM      = em_q.load;
  assign MemWrite   = em_q.memwrite;
  assign RegWrite   = mw_q.regwrite;
  assign ByteW      = mw_q.bytesel;
  assign MemtoRegW  = mw_q.memtoreg;

endmodule

// File: tb/tb_pipeline_control_decoder.sv
// Directed bench for pipeline_control_decoder: decode, stage latency, bubbles,
// freeze and asynchronous reset, with hand-computed expectations.
module tb_pipeline_control_decoder;

  localparam logic [6:0] OP_NOP    = 7'b0000000;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic       clk;
  logic       reset;
  logic       ihit;
  logic       dhit;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic       sendNop;
  logic       MemWriteD, LoadD, BranchD, JumpD, ByteD;
  logic       ALUSrcE;
  logic [2:0] ALUControl;
  logic       BranchM, JumpM, LoadM, MemWrite;
  logic       RegWrite, ByteW, MemtoRegW;

  logic [10:0] regs;
  logic [4:0]  dvec;
  int          checks;
  int          errors;

  pipeline_control_decoder dut (
    .clk       (clk),
    .reset     (reset),
    .ihit      (ihit),
    .dhit      (dhit),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7    (funct7),
    .sendNop   (sendNop),
    .MemWriteD (MemWriteD),
    .LoadD     (LoadD),
    .BranchD   (BranchD),
    .JumpD     (JumpD),
    .ByteD     (ByteD),
    .ALUSrcE   (ALUSrcE),
    .ALUControl(ALUControl),
    .BranchM   (BranchM),
    .JumpM     (JumpM),
    .LoadM     (LoadM),
    .MemWrite  (MemWrite),
    .RegWrite  (RegWrite),
    .ByteW     (ByteW),
    .MemtoRegW (MemtoRegW)
  );

  assign regs = {ALUSrcE, ALUControl, BranchM, JumpM, LoadM, MemWrite, RegWrite, ByteW, MemtoRegW};
  assign dvec = {MemWriteD, LoadD, BranchD, JumpD, ByteD};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] v(input logic a, input logic [2:0] c, input logic br,
                                    input logic jm, input logic ld, input logic mw,
                                    input logic rw, input logic bw, input logic mr);
    return {a, c, br, jm, ld, mw, rw, bw, mr};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                       input logic nop);
    opcode  = op;
    funct3  = f3;
    funct7  = f7;
    sendNop = nop;
    #1;
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    reset   = 1'b0;
    ihit    = 1'b1;
    dhit    = 1'b1;
    opcode  = OP_NOP;
    funct3  = 3'b000;
    funct7  = 7'b0000000;
    sendNop = 1'b0;
    #1 reset = 1'b1;

    // Reset state; D decode is independent of reset
    drive(OP_LOAD, 3'b000, 7'd0, 1'b0);
    chk("rst_regs", 32'(regs), 32'(0));
    chk("rst_loadd", 32'(LoadD), 32'(1));
    tick;
    chk("rst_hold", 32'(regs), 32'(0));
    reset = 1'b0;

    // Byte load through all stages
    drive(OP_LOAD, 3'b000, 7'd0, 1'b0);
    chk("ld_dvec", 32'(dvec), 32'(5'b01001));
    tick;
    chk("ld_e", 32'(regs), 32'(v(1, 3'b000, 0, 0, 0, 0, 0, 0, 0)));
    drive(OP_NOP, 3'b000, 7'd0, 1'b0);
    chk("nop_dvec", 32'(dvec), 32'(0));
    tick;
    chk("ld_m", 32'(regs), 32'(v(0, 3'b000, 0, 0, 1, 0, 0, 0, 0)));
    drive(OP_NOP, 3'b000, 7'd0, 1'b0);
    tick;
    chk("ld_w", 32'(regs), 32'(v(0, 3'b000, 0, 0, 0, 0, 1, 1, 1)));

    // R-type add / sub / mul back to back
    drive(OP_RTYPE, 3'b000, 7'b0000000, 1'b0);
    chk("radd_dvec", 32'(dvec), 32'(0));
    tick;
    chk("radd_e", 32'(regs), 32'(v(0, 3'b000, 0, 0, 0, 0, 0, 0, 0)));
    drive(OP_RTYPE, 3'b000, 7'b0100000, 1'b0);
    tick;
    chk("rsub_e", 32'(regs), 32'(v(0, 3'b001, 0, 0, 0, 0, 0, 0, 0)));
    drive(OP_RTYPE, 3'b000, 7'b0000001, 1'b0);
    tick;
    chk("rmul_e_radd_w", 32'(regs), 32'(v(0, 3'b010, 0, 0, 0, 0, 1, 0, 0)));

    // Word store then branch
    drive(OP_STORE, 3'b010, 7'd0, 1'b0);
    chk("st_dvec", 32'(dvec), 32'(5'b10000));
    tick;
    chk("st_e_rsub_w", 32'(regs), 32'(v(1, 3'b000, 0, 0, 0, 0, 1, 0, 0)));
    drive(OP_BRANCH, 3'b000, 7'd0, 1'b0);
    chk("br_dvec", 32'(dvec), 32'(5'b00100));
    tick;
    chk("br_e_st_m", 32'(regs), 32'(v(0, 3'b001, 0, 0, 0, 1, 1, 0, 0)));
    drive(OP_NOP, 3'b000, 7'd0, 1'b0);
    tick;
    chk("br_m_st_w", 32'(regs), 32'(v(0, 3'b000, 1, 0, 0, 0, 0, 0, 0)));

    // sendNop on a JAL while an older byte load moves on
    drive(OP_LOAD, 3'b000, 7'd0, 1'b0);
    tick;
    chk("ld2_e", 32'(regs), 32'(v(1, 3'b000, 0, 0, 0, 0, 0, 0, 0)));
    drive(OP_JAL, 3'b000, 7'd0, 1'b0);
    chk("jal_jumpd", 32'(JumpD), 32'(1));
    drive(OP_JAL, 3'b000, 7'd0, 1'b1);
    chk("jal_nop_dvec", 32'(dvec), 32'(0));
    tick;
    chk("bub_e_ld2_m", 32'(regs), 32'(v(0, 3'b000, 0, 0, 1, 0, 0, 0, 0)));
    drive(OP_NOP, 3'b000, 7'd0, 1'b0);
    tick;
    chk("bub_m_ld2_w", 32'(regs), 32'(v(0, 3'b000, 0, 0, 0, 0, 1, 1, 1)));

    // Fetch miss bubbles D/E but leaves D decode alone
    ihit = 1'b0;
    drive(OP_JAL, 3'b000, 7'd0, 1'b0);
    chk("imiss_jumpd", 32'(JumpD), 32'(1));
    tick;
    chk("imiss_e", 32'(regs), 32'(0));
    ihit = 1'b1;
    drive(OP_JAL, 3'b000, 7'd0, 1'b0);
    tick;
    chk("jal_e", 32'(regs), 32'(0));
    drive(OP_NOP, 3'b000, 7'd0, 1'b0);
    tick;
    chk("jal_m", 32'(regs), 32'(v(0, 3'b000, 0, 1, 0, 0, 0, 0, 0)));

    // Three-cycle data-miss freeze with a word load in M
    drive(OP_LOAD, 3'b010, 7'd0, 1'b0);
    tick;
    chk("ldw_e_jal_w", 32'(regs), 32'(v(1, 3'b000, 0, 0, 0, 0, 1, 0, 0)));
    drive(OP_RTYPE, 3'b000, 7'b0100000, 1'b0);
    tick;
    chk("pre_freeze", 32'(regs), 32'(v(0, 3'b001, 0, 0, 1, 0, 0, 0, 0)));
    drive(OP_STORE, 3'b010, 7'd0, 1'b0);
    dhit = 1'b0;
    ihit = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk($sformatf("freeze%0d", i), 32'(regs), 32'(v(0, 3'b001, 0, 0, 1, 0, 0, 0, 0)));
    end
    dhit = 1'b1;
    ihit = 1'b1;
    tick;
    chk("thaw_ldw_w", 32'(regs), 32'(v(1, 3'b000, 0, 0, 0, 0, 1, 0, 1)));
    drive(OP_NOP, 3'b000, 7'd0, 1'b0);
    tick;
    chk("thaw_rsub_w", 32'(regs), 32'(v(0, 3'b000, 0, 0, 0, 1, 1, 0, 0)));
    tick;
    chk("thaw_st_w", 32'(regs), 32'(0));

    // Mid-cycle reset during a freeze
    drive(OP_LOAD, 3'b000, 7'd0, 1'b0);
    tick;
    drive(OP_RTYPE, 3'b000, 7'b0000001, 1'b0);
    tick;
    chk("pre_rst", 32'(regs), 32'(v(0, 3'b010, 0, 0, 1, 0, 0, 0, 0)));
    dhit = 1'b0;
    #1 reset = 1'b1;
    #1;
    chk("async_rst", 32'(regs), 32'(0));
    tick;
    chk("rst_edge", 32'(regs), 32'(0));
    reset = 1'b0;
    dhit  = 1'b1;
    drive(OP_JAL, 3'b000, 7'd0, 1'b0);
    tick;
    chk("post_rst_e", 32'(regs), 32'(0));
    drive(OP_NOP, 3'b000, 7'd0, 1'b0);
    tick;
    chk("post_rst_m", 32'(regs), 32'(v(0, 3'b000, 0, 1, 0, 0, 0, 0, 0)));
    tick;
    chk("post_rst_w", 32'(regs), 32'(v(0, 3'b000, 0, 0, 0, 0, 1, 0, 0)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_control_decoder.md
# pipeline_control_decoder

Main and ALU control decoder for the 5-stage (F/D/E/M/W) multicycle RISC-V core. Decodes the instruction in D into control signals and carries them through the D/E, E/M and M/W control pipeline registers. It also handles stalls on instruction/data cache misses and bubble injection on hazards. It sits between the fetch/decode datapath and the stage-specific datapath muxes.

## Interface
No parameters.
- clk  in  1  pipeline clock, rising-edge
- reset  in  1  asynchronous, active-high; clears all control registers
- ihit  in  1  instruction cache hit; 0 = fetch miss
- dhit  in  1  data cache hit; 0 = data miss, whole pipeline frozen
- opcode  in  7  instruction[6:0] in D
- funct3  in  3  instruction[14:12] in D
- funct7  in  7  instruction[31:25] in D
- sendNop  in  1  hazard/flush request; turns the D instruction into a bubble
- MemWriteD, LoadD, BranchD, JumpD, ByteD  out  1 each  combinational D-stage decode
- ALUSrcE  out  1  E stage; 1 = immediate operand
- ALUControl  out  3  E-stage ALU operation
- BranchM, JumpM, LoadM  out  1 each  M stage
- MemWrite  out  1  M-stage store enable
- RegWrite  out  1  W-stage register-file write enable
- ByteW, MemtoRegW  out  1 each  W stage; byte load, load-result select

## Operation
- Main decode of D-stage fields (signals not listed for a row are 0):
  - 0110011 R-type: RegWrite, aluop=10.
  - 0010011 I-ALU: RegWrite, ALUSrc, aluop=00.
  - 0000011 load: RegWrite, ALUSrc, Load, MemtoReg, aluop=00.
  - 0100011 store: ALUSrc, MemWrite, aluop=00.
  - 1100011 branch: Branch, aluop=01.
  - 1101111 JAL: Jump, RegWrite, aluop=00.
  - Any other opcode, including 0000000: all zero (nop).
- Byte = 1 only for load/store with funct3=000. funct3=010 is a word access. Other funct3 values on load/store are treated as word.
- ALU decode:
  - aluop=00: ALUControl=000 (add).
  - aluop=01: ALUControl=001 (sub).
  - aluop=10, funct7=0000000: ALUControl=000 (add).
  - aluop=10, funct7=0100000: ALUControl=001 (sub).
  - aluop=10, funct7=0000001: ALUControl=010 (mul).
  - aluop=10, any other funct7: ALUControl=000.
- sendNop=1 forces all D-stage decode outputs (*D) to 0 in the same cycle.
- Pipeline registers:
  - D/E holds RegWrite, MemWrite, Load, Branch, Jump, Byte, ALUSrc, MemtoReg and ALUControl.
  - E/M holds RegWrite, MemWrite, Load, Branch, Jump, Byte, MemtoReg.
  - M/W holds RegWrite, Byte, MemtoReg.

## Timing
- Reset: asynchronous. All registered outputs go to 0 immediately and stay 0 while reset=1. This covers RegWrite, MemWrite, ALUSrcE, ALUControl=000, BranchM, JumpM, LoadM, ByteW and MemtoRegW.
- *D outputs are combinational and are not affected by reset.
- Register updates happen on the rising clk edge, under these priority rules:
  1. dhit=0: every control register holds its value (full freeze), regardless of ihit or sendNop.
  2. Else, sendNop=1 or ihit=0: D/E loads an all-zero bubble; E/M and M/W advance normally.
  3. Else: all registers advance.
- Latency from D decode:
  - E outputs (ALUSrcE, ALUControl): 1 cycle.
  - M outputs (BranchM, JumpM, LoadM, MemWrite): 2 cycles.
  - W outputs (RegWrite, ByteW, MemtoRegW): 3 cycles.
  - A freeze extends each latency by the number of dhit=0 cycles.
- A freeze lasting several cycles must not duplicate or drop any instruction.
- Reset asserted during a freeze clears all registers. Operation resumes on the first edge after reset is deasserted.

## Test plan
- Reset, then load: opcode=0000011, funct3=000.
  - Same cycle: LoadD=1, ByteD=1.
  - +1 cycle: ALUSrcE=1, ALUControl=000.
  - +2 cycles: LoadM=1.
  - +3 cycles: RegWrite=1, MemtoRegW=1, ByteW=1.
- R-type sequence, one instruction per cycle: funct7 = 0000000, then 0100000, then 0000001. ALUControl shows 000, 001, 010 on consecutive E cycles. ALUSrcE=0 throughout. RegWrite=1 three cycles after each instruction.
- Store with funct3=010 followed by a branch.
  - Store: MemWriteD=1; MemWrite=1 two cycles later; ByteW=0.
  - Branch: ALUControl=001 in E; BranchM=1 two cycles after D.
- sendNop=1 on a JAL: JumpD=0 and every downstream output is 0 for that slot. An older instruction already in E/M continues to W unchanged.
- dhit=0 held 3 cycles with a load in M: LoadM and all W outputs stay constant for 3 cycles. The pipeline resumes with no lost or duplicated slot.
- reset pulse asserted mid-cycle between clk edges: all registered outputs go to 0 before the next clk edge.
